// File: rtl/adder_err_accum.sv
// Error-metric accumulator for 8+8->9-bit approximate adders: counts errors, max |err|, sum |err|.
// Latency: sample accepted at edge T updates the metrics at edge T+2; done follows one cycle later.
// Backpressure: in_ready only in RUN while fewer than target samples taken. Optional ERR_SQ_ACC_EN adds sum_sq_err.
module adder_err_accum #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 9,
  parameter int CNT_W = 17,
  parameter int ACC_W = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   target,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    op_a,
  input  logic [IN_W-1:0]    op_b,
  input  logic [OUT_W-1:0]   approx_sum,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   n_samples,
  output logic [CNT_W-1:0]   n_err,
  output logic [OUT_W-1:0]   max_abs_err,
  output logic [ACC_W-1:0]   sum_abs_err
`ifdef ERR_SQ_ACC_EN
  ,
  output logic [2*OUT_W+CNT_W-1:0] sum_sq_err
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   target_r;
  logic [CNT_W-1:0]   accepted;

  // Stage 0: captured operands of the accepted sample
  logic               p0_vld;
  logic [IN_W-1:0]    p0_a;
  logic [IN_W-1:0]    p0_b;
  logic [OUT_W-1:0]   p0_approx;

  // Stage 1: absolute error of that sample
  logic               p1_vld;
  logic [OUT_W-1:0]   p1_abs;

  logic               fire;
  logic [OUT_W-1:0]   exact;
  logic [OUT_W:0]     err;
  logic [OUT_W:0]     err_neg;
  logic [OUT_W-1:0]   abs_c;

  // Accept only while there is budget left, so at most target samples enter
  assign in_ready = (state == RUN) && (accepted < target_r);
  assign fire     = in_valid && in_ready;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // Exact sum and |approx - exact|; err is one bit wider so its MSB is the sign
  always_comb begin
    exact   = {1'b0, p0_a} + {1'b0, p0_b};
    err     = {1'b0, p0_approx} - {1'b0, exact};
    err_neg = -err;
    abs_c   = err[OUT_W] ? err_neg[OUT_W-1:0] : err[OUT_W-1:0];
  end

`ifdef ERR_SQ_ACC_EN
  logic [2*OUT_W-1:0] abs_ext;
  logic [2*OUT_W-1:0] abs_sq;

  // Square of the stage-1 error; the true product always fits in 2*OUT_W bits
  always_comb begin
    abs_ext = {{OUT_W{1'b0}}, p1_abs};
    abs_sq  = abs_ext * abs_ext;
  end
`endif

  // Control FSM, two-stage error pipeline and metric accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      target_r    <= '0;
      accepted    <= '0;
      p0_vld      <= 1'b0;
      p0_a        <= '0;
      p0_b        <= '0;
      p0_approx   <= '0;
      p1_vld      <= 1'b0;
      p1_abs      <= '0;
      n_samples   <= '0;
      n_err       <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
`ifdef ERR_SQ_ACC_EN
      sum_sq_err  <= '0;
`endif
    end else begin
      p0_vld <= fire;
      if (fire) begin
        p0_a      <= op_a;
        p0_b      <= op_b;
        p0_approx <= approx_sum;
      end

      p1_vld <= p0_vld;
      p1_abs <= abs_c;

      if (p1_vld) begin
        n_samples   <= n_samples + CNT_W'(1);
        n_err       <= n_err + CNT_W'(p1_abs != '0);
        sum_abs_err <= sum_abs_err + ACC_W'(p1_abs);
        if (p1_abs > max_abs_err) begin
          max_abs_err <= p1_abs;
        end
`ifdef ERR_SQ_ACC_EN
        sum_sq_err  <= sum_sq_err + (2*OUT_W+CNT_W)'(abs_sq);
`endif
      end

      case (state)
        IDLE, DONE: begin
          // Pipeline is empty here, so clearing cannot race a pending update
          if (start) begin
            state       <= RUN;
            target_r    <= target;
            accepted    <= '0;
            n_samples   <= '0;
            n_err       <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
`ifdef ERR_SQ_ACC_EN
            sum_sq_err  <= '0;
`endif
          end
        end
        RUN: begin
          if (fire) begin
            accepted <= accepted + CNT_W'(1);
          end
          // Finish once every taken sample has reached the accumulators
          if ((n_samples == target_r) && !p0_vld && !p1_vld) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
